// File: rtl/axi_wr_slave_if.sv
// AXI write address, data and response channels between a write master and axi_wr_slave.
interface axi_wr_slave_if #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_wr_slave.sv
// AXI write responder for the DDR2 core: buffers one burst of W beats, issues a single
// write command, then returns the B response. One burst outstanding at a time.
module axi_wr_slave #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init_end,
    axi_wr_slave_if.slave         axi,
    output logic                  wr_req,
    input  logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_len,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_data_en,
    input  logic                  wr_done
);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [2:0] {StIdle, StData, StCmd, StWait, StResp} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [8:0]            beat_cnt_q;
    logic                  err_q;
    logic                  oversize_q;
    logic                  wr_req_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;

    logic fifo_empty;
    logic fifo_full;
    logic aw_fire;
    logic w_fire;
    logic is_last;
    logic err_nxt;
    logic push;
    logic pop;
    logic flush;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                        (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

    assign axi.awready = (state_q == StIdle) && init_end;
    // Oversize bursts are drained at full rate and thrown away.
    assign axi.wready  = (state_q == StData) && (oversize_q || !fifo_full);
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;

    assign aw_fire = axi.awvalid && axi.awready;
    assign w_fire  = axi.wvalid && axi.wready;
    assign is_last = (beat_cnt_q == {1'b0, len_q});
    assign err_nxt = err_q || (axi.wlast != is_last);

    assign push  = w_fire && !oversize_q;
    assign pop   = wr_data_en && !fifo_empty;
    assign flush = ((state_q == StData) && w_fire && is_last && (err_nxt || oversize_q)) ||
                   ((state_q == StWait) && wr_done);

    assign wr_req  = wr_req_q;
    assign wr_addr = addr_q;
    assign wr_len  = len_q;
    assign wr_data = fifo_empty ? '0 : mem[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= axi.wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            // A flush also swallows a beat pushed in the same cycle.
            if (flush) begin
                rd_ptr_q <= push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            oversize_q <= 1'b0;
            wr_req_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (aw_fire) begin
                        addr_q     <= axi.awaddr;
                        len_q      <= axi.awlen;
                        beat_cnt_q <= '0;
                        err_q      <= 1'b0;
                        oversize_q <= (32'(axi.awlen) >= FIFO_DEPTH);
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (w_fire) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        err_q      <= err_nxt;
                        if (is_last) begin
                            if (err_nxt || oversize_q) begin
                                bvalid_q <= 1'b1;
                                bresp_q  <= 2'b10;
                                state_q  <= StResp;
                            end else begin
                                wr_req_q <= 1'b1;
                                state_q  <= StCmd;
                            end
                        end
                    end
                end
                StCmd: begin
                    if (wr_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (wr_done) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= 2'b00;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    if (axi.bready) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= 2'b00;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_slave.sv
// Scoreboard bench for axi_wr_slave: directed bursts push expected commands, data and
// responses into queues; monitors on the core and B interfaces pop and compare.
`timescale 1ns/1ps
module tb_axi_wr_slave;
    localparam int unsigned AW    = 27;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          init_end;
    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_len;
    logic [DW-1:0] wr_data;
    logic          wr_data_en;
    logic          wr_done;

    axi_wr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_wr_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .init_end  (init_end),
        .axi       (axi),
        .wr_req    (wr_req),
        .wr_ack    (wr_ack),
        .wr_addr   (wr_addr),
        .wr_len    (wr_len),
        .wr_data   (wr_data),
        .wr_data_en(wr_data_en),
        .wr_done   (wr_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+7:0] exp_cmd  [$];
    logic [DW-1:0] exp_data [$];
    logic [1:0]    exp_resp [$];
    logic [AW+7:0] mon_cmd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitors: sample away from the active edge, handshakes complete at the next posedge.
    always @(negedge clk) begin
        if (rstn && wr_req && wr_ack) begin
            if (exp_cmd.size() == 0) begin
                fail_now("cmd_unexpected");
            end else begin
                mon_cmd = exp_cmd.pop_front();
                check("cmd_addr", 64'(wr_addr), 64'(mon_cmd[AW+7:8]));
                check("cmd_len", 64'(wr_len), 64'(mon_cmd[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && wr_data_en) begin
            if (exp_data.size() == 0) fail_now("pop_extra");
            else check("pop_data", 64'(wr_data), 64'(exp_data.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rstn && axi.bvalid && axi.bready) begin
            if (exp_resp.size() == 0) fail_now("resp_unexpected");
            else check("bresp", 64'(axi.bresp), 64'(exp_resp.pop_front()));
        end
    end

    // Core model: ack after two cycles, pop wr_len+1 beats back to back, then pulse wr_done.
    initial begin : core_model
        int cst;
        int cnt;
        int left;
        cst = 0;
        cnt = 0;
        left = 0;
        wr_ack = 1'b0;
        wr_data_en = 1'b0;
        wr_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wr_ack = 1'b0;
            wr_data_en = 1'b0;
            wr_done = 1'b0;
            if (!rstn) begin
                cst = 0;
            end else begin
                case (cst)
                    0: if (wr_req) begin cst = 1; cnt = 2; end
                    1: begin
                        if (cnt == 0) begin
                            wr_ack = 1'b1;
                            left = int'(wr_len) + 1;
                            cst = 2;
                        end else begin
                            cnt--;
                        end
                    end
                    2: begin
                        wr_data_en = 1'b1;
                        left--;
                        if (left == 0) cst = 3;
                    end
                    default: begin wr_done = 1'b1; cst = 0; end
                endcase
            end
        end
    end

    task automatic expect_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                                input int base, input bit ok);
        if (ok) begin
            exp_cmd.push_back({addr, len});
            for (int i = 0; i <= int'(len); i++) exp_data.push_back(DW'(base + i));
            exp_resp.push_back(2'b00);
        end else begin
            exp_resp.push_back(2'b10);
        end
    endtask

    task automatic do_aw(input logic [AW-1:0] addr, input logic [7:0] len);
        int t;
        axi.awvalid = 1'b1;
        axi.awaddr = addr;
        axi.awlen = len;
        t = 0;
        @(negedge clk);
        while (!axi.awready && t < 100) begin @(negedge clk); t++; end
        if (!axi.awready) begin
            fail_now("awready_timeout");
            axi.awvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        axi.awvalid = 1'b0;
    endtask

    task automatic send_w(input int n, input int last_at, input int base, input bit gap);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) begin
                axi.wvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            axi.wvalid = 1'b1;
            axi.wdata = DW'(base + i);
            axi.wlast = (i == last_at);
            t = 0;
            @(negedge clk);
            while (!axi.wready && t < 100) begin @(negedge clk); t++; end
            if (!axi.wready) begin
                fail_now("wready_timeout");
                axi.wvalid = 1'b0;
                axi.wlast = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        axi.wvalid = 1'b0;
        axi.wlast = 1'b0;
    endtask

    // Entered at a negedge; leaves at posedge+1.
    task automatic wait_b(input int hold);
        int t;
        t = 0;
        while (!axi.bvalid && t < 300) begin @(negedge clk); t++; end
        check("bvalid_seen", 64'(axi.bvalid), 64'd1);
        if (axi.bvalid) begin
            for (int k = 0; k < hold; k++) begin
                check("bvalid_hold", 64'(axi.bvalid), 64'd1);
                @(posedge clk);
                #1;
                if (k == hold - 1) axi.bready = 1'b1;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bvalid_drop", 64'(axi.bvalid), 64'd0);
        end
        axi.bready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_burst(input bit ok, input int hold);
        @(negedge clk);
        if (ok) check("wr_req_latency", 64'(wr_req), 64'd1);
        else check("err_bvalid_latency", 64'(axi.bvalid), 64'd1);
        wait_b(hold);
    endtask

    task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len, input int last_at,
                             input int base, input bit gap, input int hold, input bit ok);
        axi.bready = (hold == 0);
        expect_burst(addr, len, base, ok);
        do_aw(addr, len);
        send_w(int'(len) + 1, last_at, base, gap);
        finish_burst(ok, hold);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stimulus
        rstn = 1'b0;
        init_end = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr = '0;
        axi.awlen = '0;
        axi.wvalid = 1'b0;
        axi.wdata = '0;
        axi.wlast = 1'b0;
        axi.bready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(axi.awready), 64'd0);
        check("rst_wready", 64'(axi.wready), 64'd0);
        check("rst_bvalid", 64'(axi.bvalid), 64'd0);
        check("rst_bresp", 64'(axi.bresp), 64'd0);
        check("rst_wr_req", 64'(wr_req), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_len", 64'(wr_len), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // AW held while init_end is low, then accepted in the cycle init_end rises.
        axi.awaddr = AW'(16);
        axi.awlen = 8'd8;
        axi.awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("awready_before_init", 64'(axi.awready), 64'd0);
        end
        @(posedge clk);
        #1;
        init_end = 1'b1;
        expect_burst(AW'(16), 8'd8, 0, 1'b1);
        @(negedge clk);
        check("awready_after_init", 64'(axi.awready), 64'd1);
        @(posedge clk);
        #1;
        axi.awvalid = 1'b0;
        send_w(9, 8, 0, 1'b0);
        finish_burst(1'b1, 0);

        run_burst(AW'(16), 8'd8, 8, 0, 1'b1, 5, 1'b1);
        run_burst(AW'(256), 8'd20, 20, 256, 1'b0, 0, 1'b0);
        run_burst(AW'(512), 8'd8, 3, 512, 1'b0, 0, 1'b0);
        run_burst(AW'(768), 8'd8, 8, 48, 1'b0, 0, 1'b1);
        run_burst(AW'(1024), 8'd15, 15, 96, 1'b0, 0, 1'b1);

        // Reset while beat 4 is on the bus; nothing from that burst may surface.
        do_aw(AW'(64), 8'd8);
        send_w(4, 99, 64, 1'b0);
        axi.wvalid = 1'b1;
        axi.wdata = DW'(68);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_wready", 64'(axi.wready), 64'd0);
        check("midrst_bvalid", 64'(axi.bvalid), 64'd0);
        check("midrst_wr_req", 64'(wr_req), 64'd0);
        check("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check("midrst_wr_len", 64'(wr_len), 64'd0);
        check("midrst_wr_data", 64'(wr_data), 64'd0);
        @(posedge clk);
        #1;
        axi.wvalid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_burst(AW'(32), 8'd8, 8, 80, 1'b0, 0, 1'b1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        check("data_queue_drained", 64'(exp_data.size()), 64'd0);
        check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
